// File: rtl/chacha_core_iter_if.sv
// Request/response bundle for the iterative ChaCha block core: key/counter/nonce
// in over a valid/ready handshake, one 512-bit keystream block out.
interface chacha_core_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key_in;
  logic [31:0]  counter_in;
  logic [95:0]  nonce_in;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         busy;

  modport master (
    output in_valid, key_in, counter_in, nonce_in, out_ready,
    input  in_ready, out_valid, out_block, busy
  );

  modport slave (
    input  in_valid, key_in, counter_in, nonce_in, out_ready,
    output in_ready, out_valid, out_block, busy
  );
endinterface

// File: rtl/chacha_core_iter.sv
// Sequential ChaCha block function: ROUNDS rounds of ARX quarter rounds,
// QR_PER_CYCLE at a time, followed by the feed-forward add of the initial state.
module chacha_core_iter #(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 4
) (
  input logic               clk,
  input logic               rst,
  chacha_core_iter_if.slave bus
);

  if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 2 || QR_PER_CYCLE == 4)) begin : g_bad_qr
    $error("chacha_core_iter: QR_PER_CYCLE must be 1, 2 or 4");
  end
  if (ROUNDS < 2 || ROUNDS > 254 || (ROUNDS % 2) != 0) begin : g_bad_rounds
    $error("chacha_core_iter: ROUNDS must be even and in 2..254");
  end

  typedef logic [31:0]       word_t;
  typedef logic [15:0][31:0] block_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  localparam int         CYCLES_PER_ROUND = 4 / QR_PER_CYCLE;
  localparam logic [1:0] LAST_STEP        = 2'(CYCLES_PER_ROUND - 1);
  localparam logic [7:0] LAST_ROUND       = 8'(ROUNDS - 1);
  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Group g of a column round is (g, g+4, g+8, g+12); a diagonal round shifts
  // rows 1..3 left by 1..3 positions within their row.
  function automatic block_t apply_group(input block_t s, input logic [1:0] g, input logic diag);
    logic [3:0] ia, ib, ic, id;
    word_t      a, b, c, d;
    block_t     r;
    ia = {2'd0, g};
    ib = {2'd1, diag ? 2'(g + 2'd1) : g};
    ic = {2'd2, diag ? 2'(g + 2'd2) : g};
    id = {2'd3, diag ? 2'(g + 2'd3) : g};
    a = s[ia]; b = s[ib]; c = s[ic]; d = s[id];
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    r = s;
    r[ia] = a; r[ib] = b; r[ic] = c; r[id] = d;
    return r;
  endfunction

  state_t     state_q, state_d;
  block_t     work_q, init_q, out_q;
  block_t     next_work, sum_block, load_block;
  logic [1:0] step_q;
  logic [7:0] round_q;

  assign load_block = {bus.nonce_in, bus.counter_in, bus.key_in, SIGMA};

  // NOTE: every signal written in an always_comb gets a default on the first
  // line, so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    next_work = work_q;
    for (int j = 0; j < QR_PER_CYCLE; j++) begin
      next_work = apply_group(next_work, 2'(int'(step_q) * QR_PER_CYCLE + j), round_q[0]);
    end
  end

  always_comb begin
    sum_block = '0;
    for (int i = 0; i < 16; i++) begin
      sum_block[i] = work_q[i] + init_q[i];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_ROUND;
      S_ROUND: if (step_q == LAST_STEP && round_q == LAST_ROUND) state_d = S_FINAL;
      S_FINAL: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the work/init/output register files are cleared by reset because an
  // aborted job must not leave keystream material visible on out_block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q  <= '0;
      init_q  <= '0;
      out_q   <= '0;
      step_q  <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            work_q  <= load_block;
            init_q  <= load_block;
            step_q  <= '0;
            round_q <= '0;
          end
        end
        S_ROUND: begin
          work_q <= next_work;
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            round_q <= round_q + 8'd1;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        S_FINAL: out_q <= sum_block;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_block = out_q;

endmodule

// File: tb/tb_chacha_core_iter.sv
// Bench for chacha_core_iter: five parameterisations share one stimulus bus and
// are compared against an RFC-style double-round reference model.
module tb_chacha_core_iter;

  localparam int NDUT = 5;
  localparam int DUT_ROUNDS [NDUT] = '{20, 20, 20, 8, 12};
  localparam int DUT_QR     [NDUT] = '{4, 2, 1, 4, 4};

  localparam logic [255:0] RFC_KEY = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                      32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [31:0]  RFC_CTR   = 32'h00000001;
  localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};

  typedef struct {
    logic [255:0]           key;
    logic [31:0]            ctr;
    logic [95:0]            nonce;
    logic [NDUT-1:0][511:0] exp;
  } vec_t;

  logic clk, rst;
  logic         in_valid, out_ready;
  logic [255:0] key_s;
  logic [31:0]  ctr_s;
  logic [95:0]  nonce_s;

  logic [NDUT-1:0] ov, ir, bz;
  logic [511:0]    ob [NDUT];

  int n_checks, n_pass;
  int res_lat [NDUT];
  logic [511:0] res_blk [NDUT];
  int busy_cnt, ov_cnt;
  logic ir_done, ir_after;
  vec_t vecs [4];

  chacha_core_iter_if bus [NDUT] ();

  for (genvar k = 0; k < NDUT; k++) begin : g_conn
    assign bus[k].in_valid   = in_valid;
    assign bus[k].key_in     = key_s;
    assign bus[k].counter_in = ctr_s;
    assign bus[k].nonce_in   = nonce_s;
    assign bus[k].out_ready  = out_ready;
    assign ov[k] = bus[k].out_valid;
    assign ir[k] = bus[k].in_ready;
    assign bz[k] = bus[k].busy;
    assign ob[k] = bus[k].out_block;
  end

  chacha_core_iter #(.ROUNDS(20), .QR_PER_CYCLE(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus[0]));
  chacha_core_iter #(.ROUNDS(20), .QR_PER_CYCLE(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus[1]));
  chacha_core_iter #(.ROUNDS(20), .QR_PER_CYCLE(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus[2]));
  chacha_core_iter #(.ROUNDS(8),  .QR_PER_CYCLE(4)) u_dut3 (.clk(clk), .rst(rst), .bus(bus[3]));
  chacha_core_iter #(.ROUNDS(12), .QR_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int unsigned rotl32(input int unsigned x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference: RFC 8439 block function, written as double rounds of eight quarter rounds.
  function automatic logic [511:0] chacha_ref(input logic [255:0] key, input logic [31:0] ctr,
                                               input logic [95:0] nonce, input int rounds);
    int unsigned s [16];
    int unsigned x [16];
    int qi [8][4];
    logic [511:0] r;
    qi = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
           '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int k = 0; k < 8; k++) s[4 + k] = key[32*k +: 32];
    s[12] = ctr;
    for (int n = 0; n < 3; n++) s[13 + n] = nonce[32*n +: 32];
    x = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int q = 0; q < 8; q++) begin
        int a, b, c, d;
        a = qi[q][0]; b = qi[q][1]; c = qi[q][2]; d = qi[q][3];
        x[a] = x[a] + x[b]; x[d] = rotl32(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl32(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl32(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl32(x[b] ^ x[c], 7);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic launch(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
    @(negedge clk);
    key_s = k; ctr_s = c; nonce_s = n; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Accept a request on all cores, then watch 101 cycles (t = cycles after the accept edge).
  task automatic run_all(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
    logic [NDUT-1:0] seen;
    seen = '0; busy_cnt = 0; ov_cnt = 0; ir_done = 1'bx; ir_after = 1'bx;
    for (int i = 0; i < NDUT; i++) begin res_lat[i] = -1; res_blk[i] = 'x; end
    launch(k, c, n);
    for (int t = 0; t <= 100; t++) begin
      @(negedge clk);
      if (bz[0]) busy_cnt++;
      if (ov[0]) ov_cnt++;
      if (seen[0] && t == res_lat[0] + 1) ir_after = ir[0];
      for (int i = 0; i < NDUT; i++) begin
        if (ov[i] && !seen[i]) begin
          seen[i] = 1'b1; res_lat[i] = t; res_blk[i] = ob[i];
          if (i == 0) ir_done = ir[0];
        end
      end
    end
  endtask

  task automatic check_run(input string tag, input logic [NDUT-1:0][511:0] exp);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_lat%0d", tag, i), res_lat[i], DUT_ROUNDS[i] * 4 / DUT_QR[i] + 1);
      check($sformatf("%s_blk%0d", tag, i), res_blk[i], exp[i]);
    end
    check({tag, "_busy_cycles"}, busy_cnt, 22);
    check({tag, "_valid_cycles"}, ov_cnt, 1);
    check({tag, "_in_ready_done"}, ir_done, 1'b0);
    check({tag, "_in_ready_after"}, ir_after, 1'b1);
  endtask

  function automatic logic [NDUT-1:0][511:0] expect_all(input logic [255:0] k, input logic [31:0] c,
                                                       input logic [95:0] n);
    logic [NDUT-1:0][511:0] e;
    for (int i = 0; i < NDUT; i++) e[i] = chacha_ref(k, c, n, DUT_ROUNDS[i]);
    return e;
  endfunction

  initial begin
    logic [511:0] held [NDUT];
    int bad, extra;
    n_checks = 0; n_pass = 0;
    in_valid = 1'b0; out_ready = 1'b1; key_s = '0; ctr_s = '0; nonce_s = '0;

    // Reset and idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", ir[0], 1'b1);
    check("rst_out_valid", ov[0], 1'b0);
    check("rst_busy", bz[0], 1'b0);
    check("rst_out_block", ob[0], '0);
    check("rst_all_flags", {ir, ov, bz}, {{NDUT{1'b1}}, {NDUT{1'b0}}, {NDUT{1'b0}}});

    // Vector table: RFC inputs first, then random requests
    vecs[0].key = RFC_KEY; vecs[0].ctr = RFC_CTR; vecs[0].nonce = RFC_NONCE;
    for (int v = 1; v < 4; v++) begin
      vecs[v].key   = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
      vecs[v].ctr   = $urandom();
      vecs[v].nonce = {$urandom(), $urandom(), $urandom()};
    end
    for (int v = 0; v < 4; v++) vecs[v].exp = expect_all(vecs[v].key, vecs[v].ctr, vecs[v].nonce);

    for (int v = 0; v < 4; v++) begin
      run_all(vecs[v].key, vecs[v].ctr, vecs[v].nonce);
      check_run($sformatf("vec%0d", v), vecs[v].exp);
      if (v == 0) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("rfc_w0_q%0d", DUT_QR[i]),  res_blk[i][31:0],    32'he4e7f110);
          check($sformatf("rfc_w1_q%0d", DUT_QR[i]),  res_blk[i][63:32],   32'h15593bd1);
          check($sformatf("rfc_w15_q%0d", DUT_QR[i]), res_blk[i][511:480], 32'h4e3c50a2);
        end
      end
    end

    // Backpressure: results held in DONE, in_valid pulses ignored, single handoff
    out_ready = 1'b0;
    launch(vecs[1].key, vecs[1].ctr, vecs[1].nonce);
    for (int t = 0; t < 150 && ov !== {NDUT{1'b1}}; t++) @(negedge clk);
    check("bp_all_done", ov, {NDUT{1'b1}});
    for (int i = 0; i < NDUT; i++) held[i] = ob[i];
    check("bp_block0", held[0], vecs[1].exp[0]);
    check("bp_block3", held[3], vecs[1].exp[3]);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
        if (ob[i] !== held[i] || ov[i] !== 1'b1 || ir[i] !== 1'b0) bad++;
      in_valid = c[0];
      key_s = {8{$urandom()}};
    end
    check("bp_stable", bad, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_handoff_valid", ov, '0);
    check("bp_handoff_ready", ir, {NDUT{1'b1}});
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ov != '0) extra++;
    end
    check("bp_no_extra_block", extra, 0);
    check("bp_block_retained", ob[0], held[0]);

    // Reset in the middle of round 7
    launch(vecs[2].key, vecs[2].ctr, vecs[2].nonce);
    repeat (8) @(negedge clk);
    check("mid_busy_before", bz[0], 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", ir, {NDUT{1'b1}});
    check("mid_rst_busy", bz, '0);
    check("mid_rst_out_valid", ov, '0);
    check("mid_rst_out_block", ob[0], '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_all(RFC_KEY, RFC_CTR, RFC_NONCE);
    check_run("after_rst", vecs[0].exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chacha_core_iter.md
Name: chacha_core_iter

Overview:
- Parametrised, sequential ChaCha block-function core built around the existing 32-bit ARX quarter round (add, xor, rotate 16/12/8/7).
- Accepts a key, block counter and nonce through a valid/ready handshake.
- Iterates ROUNDS rounds using QR_PER_CYCLE quarter-round instances in parallel, then adds the initial state back in.
- Returns one 512-bit keystream block through a valid/ready handshake. It is the keystream source for the RNG output stage.

Parameters:
- ROUNDS, 20, total rounds. Must be even and at least 2 (8, 12 and 20 are supported).
- QR_PER_CYCLE, 4, quarter rounds evaluated per clock. Legal values are 1, 2 and 4; other values stop elaboration.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  key/counter/nonce are valid.
- in_ready  output  1  core is idle and can accept a request.
- key_in  input  256  key; word k is bits [32k+31:32k], k=0..7.
- counter_in  input  32  block counter.
- nonce_in  input  96  nonce; word n is bits [32n+31:32n], n=0..2.
- out_valid  output  1  out_block holds a finished keystream block.
- out_ready  input  1  consumer accepts out_block.
- out_block  output  512  keystream; state word i is bits [32i+31:32i].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-round):
  - state goes to IDLE; in_ready=1, out_valid=0, busy=0, out_block=0.
  - Work, init and step registers clear; the in-flight job is discarded.
- State layout (16 x 32-bit words):
  - w0..w3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
  - w4..w11 = key words 0..7; w12 = counter_in; w13..w15 = nonce words 0..2.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge, load the state into both the work and init registers, clear step/round counters, go to ROUND.
  - Inputs are sampled only at that edge.
- ROUND: each edge applies QR_PER_CYCLE quarter rounds to the work registers.
  - Even (column) round groups are (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - Odd (diagonal) round groups are (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - Groups are processed in that listed order, QR_PER_CYCLE at a time.
  - Cycles per round = 4/QR_PER_CYCLE. Total ROUND cycles C = ROUNDS*4/QR_PER_CYCLE.
- Quarter round on (a,b,c,d):
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
  - All additions are mod 2^32, carries discarded. Rotations are left rotations.
- FINAL:
  - One edge registers out_block word i = work_i + init_i mod 2^32.
  - out_valid rises after that edge; go to DONE.
- Latency: request accepted at edge N gives out_valid high after edge N+C+1. With defaults this is N+21; with QR_PER_CYCLE=1 it is N+81.
- DONE:
  - out_valid=1, in_ready=0; out_block is held stable until accepted.
  - On out_valid&out_ready at an edge, out_valid drops and the state goes to IDLE.
  - in_ready rises the next cycle; no same-cycle accept/restart.
- Backpressure:
  - While out_ready is low, DONE persists indefinitely and out_block does not change.
  - in_valid is ignored in every state except IDLE.
- in_ready and busy are decoded from the state register only (no combinational path from any input).
- out_block keeps its last value after handoff until the next FINAL.

Test Plan:
1. Reset then idle: hold rst for 3 cycles, release -> in_ready=1, out_valid=0, busy=0, out_block=0.
2. RFC 8439 §2.3.2 vector:
   - Stimulus: key bytes 00..1f (w4=0x03020100), counter=1, nonce words 0x09000000, 0x4a000000, 0x00000000, ROUNDS=20.
   - Required: word0=0xe4e7f110, word1=0x15593bd1, word15=0x4e3c50a2.
   - Repeat for QR_PER_CYCLE = 1, 2, 4; the result must be identical in all three.
3. Latency and handshake: defaults, accept at edge N with out_ready=1 -> out_valid first high after edge N+21, busy high for 22 cycles, in_ready back to 1 one cycle after the handoff edge.
4. Backpressure: hold out_ready=0 for 50 cycles after out_valid -> out_block constant and in_valid pulses ignored; raise out_ready -> exactly one handoff.
5. Reset mid-operation: assert rst at round 7 -> outputs return to reset values immediately; a new request after release produces the correct vector-2 result.
6. Reduced rounds: ROUNDS=8 and ROUNDS=12 with the vector-2 inputs -> result matches a software ChaCha8/ChaCha12 model; latency is C+1 (9 and 13 with defaults).
